// File: rtl/text_memory_loader.sv
// Text memory loader: unpacks a framed byte stream (SYNC, LEN_LO, LEN_HI, data) into 32-bit LE writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module text_memory_loader #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter bit          HOLD_AT_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    // state  | meaning
    // IDLE   | hunting for SYNC_BYTE, other bytes dropped
    // LEN_LO | expecting low byte of word count
    // LEN_HI | expecting high byte, range-checks the count
    // DATA   | packing data bytes into words
    // CSUM   | expecting XOR checksum byte (checksum build only)
    // FINISH | load complete, releases core
    // ERR    | frame rejected, core stays held
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, FINISH, ERR} state_t;

    localparam logic [16:0] MEM_WORDS = 17'd1 << ADDR_WIDTH;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = FINISH;
`endif

    state_t      state, stateNext;
    logic [7:0]  lenLo;
    logic [15:0] len;
    logic [15:0] wordsRecv;
    logic [1:0]  byteCnt;
    logic [23:0] shiftReg;
    logic        accept;
    logic [15:0] lenNew;
    logic        lastWord;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept   = in_valid & in_ready;
    assign lenNew   = {in_data, lenLo};
    assign lastWord = (wordsRecv + 16'd1) == len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        in_ready  = (state != FINISH) && (state != ERR);
        busy      = (state != IDLE);
        done      = (state == FINISH);
        case (state)
            IDLE:   if (accept && in_data == SYNC_BYTE) stateNext = LEN_LO;
            LEN_LO: if (accept) stateNext = LEN_HI;
            LEN_HI: if (accept) begin
                if (lenNew == 16'd0)                 stateNext = AFTER_DATA;
                else if ({1'b0, lenNew} > MEM_WORDS) stateNext = ERR;
                else                                 stateNext = DATA;
            end
            DATA:   if (accept && byteCnt == 2'd3 && lastWord) stateNext = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            CSUM:   if (accept) stateNext = (in_data == csum) ? FINISH : ERR;
`endif
            FINISH: stateNext = IDLE;
            ERR:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_rst     <= HOLD_AT_RESET;
            error        <= 1'b0;
            words_loaded <= '0;
            lenLo        <= '0;
            len          <= '0;
            wordsRecv    <= '0;
            byteCnt      <= '0;
            shiftReg     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            // Address/count advance after the pulse so mem_addr shows the written word's index.
            if (mem_we) begin
                mem_addr     <= mem_addr + ADDR_WIDTH'(1);
                words_loaded <= words_loaded + 16'd1;
            end
            case (state)
                IDLE: if (accept && in_data == SYNC_BYTE) begin
                    core_rst     <= 1'b1;
                    error        <= 1'b0;
                    words_loaded <= '0;
                    byteCnt      <= '0;
                    mem_addr     <= '0;
                    wordsRecv    <= '0;
`ifdef LOADER_CHECKSUM_EN
                    csum         <= '0;
`endif
                end
                LEN_LO: if (accept) lenLo <= in_data;
                LEN_HI: if (accept) len <= lenNew;
                DATA: if (accept) begin
                    byteCnt <= byteCnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum    <= csum ^ in_data;
`endif
                    case (byteCnt)
                        2'd0: shiftReg[7:0]   <= in_data;
                        2'd1: shiftReg[15:8]  <= in_data;
                        2'd2: shiftReg[23:16] <= in_data;
                        default: begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {in_data, shiftReg};
                            wordsRecv <= wordsRecv + 16'd1;
                        end
                    endcase
                end
                FINISH: core_rst <= 1'b0;
                ERR:    error    <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_memory_loader.sv
module tb_text_memory_loader;
   localparam int AW = 8;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {logic [AW-1:0] addr; logic [31:0] data;} wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_rst;
   logic          busy;
   logic          done;
   logic          error;
   logic [15:0]   words_loaded;

   always #5 clk = ~clk;

   text_memory_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .HOLD_AT_RESET(1'b1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
      .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
   );

   int   n_cmp = 0, n_err = 0;
   wr_t  got_w[$], exp_w[$];
   int   done_cnt = 0, seq_viol = 0, ready_viol = 0, timeouts = 0;
   logic prev_done = 1'b0;
   logic m_core_rst, m_err;
   int   m_done, m_words;

   always @(negedge clk) begin
      if (mem_we) got_w.push_back({mem_addr, mem_wdata});
      if (done) done_cnt++;
      if (done && !core_rst) seq_viol++;
      if (prev_done && core_rst) seq_viol++;
      if (!in_ready && !busy) ready_viol++;
      prev_done = done;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic report_fail(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic model(input bq_t bs);
      int i, len;
      logic [7:0] x;
      exp_w.delete();
      m_done = 0;
      i = 0;
      while (i < bs.size()) begin
         if (bs[i] != 8'hA5) begin i++; continue; end
         m_err = 1'b0; m_core_rst = 1'b1; m_words = 0;
         if (i + 2 >= bs.size()) break;
         len = int'(bs[i+1]) + 256 * int'(bs[i+2]);
         i += 3;
         if (len > (1 << AW)) begin m_err = 1'b1; continue; end
         x = 8'h00;
         for (int k = 0; k < len; k++) begin
            exp_w.push_back({AW'(k), bs[i+4*k+3], bs[i+4*k+2], bs[i+4*k+1], bs[i+4*k]});
            x = x ^ bs[i+4*k] ^ bs[i+4*k+1] ^ bs[i+4*k+2] ^ bs[i+4*k+3];
            m_words++;
         end
         i += 4 * len;
`ifdef LOADER_CHECKSUM_EN
         if (i >= bs.size()) break;
         if (bs[i] != x) begin i++; m_err = 1'b1; continue; end
         i++;
`endif
         m_done++;
         m_core_rst = 1'b0;
      end
   endtask

   function automatic bq_t mk_frame(input int len, input int junk);
      bq_t q;
      logic [7:0] x, b;
      x = 8'h00;
      for (int k = 0; k < junk; k++) q.push_back(8'($urandom_range(164, 0)));
      q.push_back(8'hA5);
      q.push_back(8'(len));
      q.push_back(8'(len >> 8));
      for (int k = 0; k < 4 * len; k++) begin
         b = 8'($urandom);
         x ^= b;
         q.push_back(b);
      end
`ifdef LOADER_CHECKSUM_EN
      q.push_back(x);
`endif
      return q;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int tries;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = b;
      tries = 0;
      while (!in_ready && tries < 50) begin @(posedge clk); #1; tries++; end
      if (tries >= 50) timeouts++;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_w.delete();
      done_cnt = 0; seq_viol = 0; ready_viol = 0; timeouts = 0;
   endtask

   task automatic run_stream(input string tag, input bq_t bs, input int min_gap, input int max_gap);
      clear_mon();
      model(bs);
      foreach (bs[i]) send_byte(bs[i], $urandom_range(max_gap, min_gap));
      drain();
      n_cmp++;
      if (got_w.size() !== exp_w.size()) report_fail({tag, " write count"}, got_w.size(), exp_w.size());
      for (int k = 0; k < got_w.size() && k < exp_w.size(); k++) begin
         n_cmp++;
         if (got_w[k] !== exp_w[k]) report_fail({tag, " write"}, got_w[k], exp_w[k]);
      end
      n_cmp++;
      if (done_cnt !== m_done) report_fail({tag, " done pulses"}, done_cnt, m_done);
      n_cmp++;
      if (error !== m_err) report_fail({tag, " error"}, error, m_err);
      n_cmp++;
      if (core_rst !== m_core_rst) report_fail({tag, " core_rst"}, core_rst, m_core_rst);
      n_cmp++;
      if (words_loaded !== 16'(m_words)) report_fail({tag, " words_loaded"}, words_loaded, m_words);
      n_cmp++;
      if (busy !== 1'b0) report_fail({tag, " busy idle"}, busy, 0);
      n_cmp++;
      if (seq_viol !== 0) report_fail({tag, " core_rst/done order"}, seq_viol, 0);
      n_cmp++;
      if (ready_viol !== 0) report_fail({tag, " in_ready while idle"}, ready_viol, 0);
      n_cmp++;
      if (timeouts !== 0) report_fail({tag, " handshake timeout"}, timeouts, 0);
   endtask

   task automatic check_reset_values(input string tag);
      n_cmp++;
      if (in_ready !== 1'b1) report_fail({tag, " in_ready"}, in_ready, 1);
      n_cmp++;
      if (mem_we !== 1'b0) report_fail({tag, " mem_we"}, mem_we, 0);
      n_cmp++;
      if (mem_addr !== AW'(0)) report_fail({tag, " mem_addr"}, mem_addr, 0);
      n_cmp++;
      if (mem_wdata !== 32'h0) report_fail({tag, " mem_wdata"}, mem_wdata, 0);
      n_cmp++;
      if (core_rst !== 1'b1) report_fail({tag, " core_rst"}, core_rst, 1);
      n_cmp++;
      if (busy !== 1'b0) report_fail({tag, " busy"}, busy, 0);
      n_cmp++;
      if (done !== 1'b0) report_fail({tag, " done"}, done, 0);
      n_cmp++;
      if (error !== 1'b0) report_fail({tag, " error"}, error, 0);
      n_cmp++;
      if (words_loaded !== 16'h0) report_fail({tag, " words_loaded"}, words_loaded, 0);
   endtask

   initial begin
      bq_t s, f;
      logic [7:0] d[6];
      wr_t w0;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      m_core_rst = 1'b1; m_err = 1'b0; m_words = 0;
      @(posedge clk); #1;

      s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      s.push_back(8'h90);
`endif
      run_stream("t1", s, 0, 0);
      w0 = (got_w.size() > 0) ? got_w[0] : '0;
      n_cmp++;
      if (w0 !== {AW'(0), 32'h00000013}) report_fail("t1 word0 literal", w0, {AW'(0), 32'h00000013});

      s = '{8'hFF, 8'h00, 8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      s.push_back(8'h00);
`endif
      run_stream("t2", s, 0, 0);

      s = '{8'hA5, 8'h01, 8'h01};
      run_stream("t3", s, 0, 0);
      clear_mon();
      send_byte(8'hA5, 0);
      n_cmp++;
      if (error !== 1'b0) report_fail("t3 error cleared by sync", error, 0);
      n_cmp++;
      if (busy !== 1'b1) report_fail("t3 busy after sync", busy, 1);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00, 0);
`endif
      drain();
      n_cmp++;
      if (done_cnt !== 1) report_fail("t3b done pulses", done_cnt, 1);
      n_cmp++;
      if (core_rst !== 1'b0) report_fail("t3b core_rst released", core_rst, 0);
      m_core_rst = 1'b0; m_err = 1'b0; m_words = 0;

      f = mk_frame(3, 0);
      run_stream("t4 b2b", f, 0, 0);
      run_stream("t4 alt", f, 1, 1);
      run_stream("t4 rnd", f, 0, 4);

      clear_mon();
      send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
      for (int k = 0; k < 6; k++) begin
         d[k] = 8'($urandom);
         send_byte(d[k], 0);
      end
      n_cmp++;
      if (busy !== 1'b1) report_fail("t5 busy before rst", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_reset_values("t5 async");
      n_cmp++;
      if (got_w.size() !== 1) report_fail("t5 writes before rst", got_w.size(), 1);
      w0 = (got_w.size() > 0) ? got_w[0] : '0;
      n_cmp++;
      if (w0 !== {AW'(0), d[3], d[2], d[1], d[0]}) report_fail("t5 word0", w0, {AW'(0), d[3], d[2], d[1], d[0]});
      @(posedge clk); #1;
      rst = 1'b0;
      m_core_rst = 1'b1; m_err = 1'b0; m_words = 0;
      @(posedge clk); #1;
      run_stream("t5 fresh", mk_frame(2, 0), 0, 1);

`ifdef LOADER_CHECKSUM_EN
      s = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      run_stream("t6 good", s, 0, 0);
      s[7] = 8'h45;
      run_stream("t6 bad", s, 0, 0);
`endif

      for (int n = 0; n < 15; n++) begin
         f = mk_frame($urandom_range(8, 1), $urandom_range(2, 0));
`ifdef LOADER_CHECKSUM_EN
         if ($urandom_range(3, 0) == 0) f[f.size()-1] ^= 8'h5A;
`endif
         run_stream("rand", f, 0, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
